egg_control: RTL and testbench

EGG_CONTROL -- requirements
Module: egg_control

---
 rtl/egg_control.sv | 194 +++++++++++++++++++
 tb/tb_egg_control.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egg_control.sv
// -----------------------------------------------------------------------------
// egg_control
//
// Control FSM for a kitchen egg timer. It owns the MM:SS setpoint (entered with
// the minute/second buttons while idle), asks the external BCD countdown timer
// to load that setpoint, gates the countdown (run/pause), and drives the alarm
// for ALARM_SECS seconds once the countdown reaches zero.
//
// Parameters
//   ALARM_SECS   number of tick_1Hz strobes the alarm stays on (1..255)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   tick_1Hz       one-cycle strobe, once per second
//   btn_start      start / pause / resume pulse
//   btn_min        increment minutes setpoint pulse
//   btn_sec        increment seconds setpoint pulse
//   btn_clear      clear setpoint / abort pulse
//   cnt_zero       countdown timer digits are all zero
//   load_min_tens  setpoint, BCD minutes tens digit
//   load_min_ones  setpoint, BCD minutes ones digit
//   load_sec_tens  setpoint, BCD seconds tens digit (0..5)
//   load_sec_ones  setpoint, BCD seconds ones digit
//   load           timer load request
//   enable         countdown enable
//   enable_timer   timer active (low: timer forces its digits to zero)
//   alarm          buzzer / LED drive
//   state          state code: IDLE=0 LOAD=1 RUN=2 PAUSE=3 ALARM=4
// -----------------------------------------------------------------------------
module egg_control #(
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       btn_start,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_clear,
    input  logic       cnt_zero,
    output logic [3:0] load_min_tens,
    output logic [3:0] load_min_ones,
    output logic [3:0] load_sec_tens,
    output logic [3:0] load_sec_ones,
    output logic       load,
    output logic       enable,
    output logic       enable_timer,
    output logic       alarm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        ALARM = 3'd4
    } state_t;

    // The one button that wins this cycle; everything else is dropped.
    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_CLEAR,
        BTN_START,
        BTN_MIN,
        BTN_SEC
    } btn_t;

    state_t     cur_state;
    state_t     nxt_state;
    btn_t       btn;
    logic       armed;
    logic [7:0] alarm_cnt;
    logic       setpoint_nonzero;

    // Two-digit BCD increment that wraps to 00 after {tens_max, 9}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] tens,
                                           input logic [3:0] ones,
                                           input logic [3:0] tens_max);
        logic [7:0] r;
        if (ones == 4'd9) begin
            if (tens == tens_max) r = 8'h00;
            else                  r = {tens + 4'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
        return r;
    endfunction

    // Fixed-priority button resolution: clear > start > min > sec.
    always_comb begin
        if      (btn_clear) btn = BTN_CLEAR;
        else if (btn_start) btn = BTN_START;
        else if (btn_min)   btn = BTN_MIN;
        else if (btn_sec)   btn = BTN_SEC;
        else                btn = BTN_NONE;
    end

    assign setpoint_nonzero = |{load_min_tens, load_min_ones,
                                load_sec_tens, load_sec_ones};

    always_comb begin
        // NOTE: default first so every path assigns nxt_state and no latch is inferred.
        nxt_state = cur_state;
        case (cur_state)
            IDLE: begin
                if (btn == BTN_START && setpoint_nonzero) nxt_state = LOAD;
            end
            LOAD: begin
                // Buttons are ignored here; only the tick moves us on.
                if (tick_1Hz) nxt_state = RUN;
            end
            RUN: begin
                if      (btn == BTN_CLEAR)   nxt_state = IDLE;
                else if (btn == BTN_START)   nxt_state = PAUSE;
                else if (armed && cnt_zero)  nxt_state = ALARM;
            end
            PAUSE: begin
                if      (btn == BTN_CLEAR) nxt_state = IDLE;
                else if (btn == BTN_START) nxt_state = RUN;
            end
            ALARM: begin
                // Any button silences; otherwise leave on the tick that
                // takes the counter from 1 to 0.
                if (btn != BTN_NONE)                     nxt_state = IDLE;
                else if (tick_1Hz && alarm_cnt <= 8'd1)  nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register and depend on state alone.
    // NOTE: every register here, including the alarm counter, is cleared by the
    // asynchronous reset so an abort never leaves a stale load pulse behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state    <= IDLE;
            load         <= 1'b0;
            enable       <= 1'b0;
            enable_timer <= 1'b0;
            alarm        <= 1'b0;
            armed        <= 1'b0;
            alarm_cnt    <= 8'd0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            cur_state    <= nxt_state;
            load         <= (nxt_state == LOAD);
            enable       <= (nxt_state == RUN);
            enable_timer <= (nxt_state != IDLE);
            alarm        <= (nxt_state == ALARM);

            // armed guards against alarming on the stale zero the timer shows
            // right after a load, before it has counted anything.
            if (cur_state != LOAD && nxt_state == LOAD) armed <= 1'b0;
            else if (cur_state == RUN && !cnt_zero)     armed <= 1'b1;

            if (cur_state != ALARM && nxt_state == ALARM)
                alarm_cnt <= 8'(ALARM_SECS);
            else if (nxt_state == IDLE)
                alarm_cnt <= 8'd0;
            else if (cur_state == ALARM && tick_1Hz && alarm_cnt != 8'd0)
                alarm_cnt <= alarm_cnt - 8'd1;
        end
    end

    // Setpoint registers: only editable while idle, kept on every exit to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_min_tens <= 4'd0;
            load_min_ones <= 4'd0;
            load_sec_tens <= 4'd0;
            load_sec_ones <= 4'd0;
        end else if (cur_state == IDLE) begin
            case (btn)
                BTN_CLEAR: begin
                    load_min_tens <= 4'd0;
                    load_min_ones <= 4'd0;
                    load_sec_tens <= 4'd0;
                    load_sec_ones <= 4'd0;
                end
                BTN_MIN: {load_min_tens, load_min_ones} <=
                    bcd_inc(load_min_tens, load_min_ones, 4'd9);
                BTN_SEC: {load_sec_tens, load_sec_ones} <=
                    bcd_inc(load_sec_tens, load_sec_ones, 4'd5);
                default: ;
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_egg_control.sv
// -----------------------------------------------------------------------------
// tb_egg_control
//
// Self-checking bench for egg_control (ALARM_SECS = 3). A behavioural model
// keeps the setpoint as plain integer minutes/seconds and the mode as a state
// code; the DUT outputs are compared against it at every negative clock edge,
// with additional spot checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_egg_control;

    localparam int ALARM_SECS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_ALARM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1Hz = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_min = 1'b0;
    logic       btn_sec = 1'b0;
    logic       btn_clear = 1'b0;
    logic       cnt_zero = 1'b1;
    logic [3:0] load_min_tens, load_min_ones, load_sec_tens, load_sec_ones;
    logic       load, enable, enable_timer, alarm;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    // Reference model
    int m_state;
    int m_min;
    int m_sec;
    int m_cnt;
    bit m_armed;

    egg_control #(.ALARM_SECS(ALARM_SECS)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick_1Hz      (tick_1Hz),
        .btn_start     (btn_start),
        .btn_min       (btn_min),
        .btn_sec       (btn_sec),
        .btn_clear     (btn_clear),
        .cnt_zero      (cnt_zero),
        .load_min_tens (load_min_tens),
        .load_min_ones (load_min_ones),
        .load_sec_tens (load_sec_tens),
        .load_sec_ones (load_sec_ones),
        .load          (load),
        .enable        (enable),
        .enable_timer  (enable_timer),
        .alarm         (alarm),
        .state         (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // {state, load, enable, enable_timer, alarm, mm, ss}
    function automatic logic [22:0] dut_vec();
        return {state, load, enable, enable_timer, alarm,
                load_min_tens, load_min_ones, load_sec_tens, load_sec_ones};
    endfunction

    function automatic logic [22:0] exp_vec();
        logic [3:0] mt, mo, st, so;
        mt = 4'(m_min / 10);
        mo = 4'(m_min % 10);
        st = 4'(m_sec / 10);
        so = 4'(m_sec % 10);
        return {3'(m_state), (m_state == M_LOAD), (m_state == M_RUN),
                (m_state != M_IDLE), (m_state == M_ALARM), mt, mo, st, so};
    endfunction

    function automatic logic [15:0] dut_setpoint();
        return {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones};
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_min   = 0;
        m_sec   = 0;
        m_cnt   = 0;
        m_armed = 1'b0;
    endtask

    // One clock of the specified behaviour, at the level of minutes/seconds.
    task automatic model_step(input bit c, input bit s, input bit mn,
                              input bit sc, input bit tk, input bit z);
        int  ns;
        bit  any_btn;
        any_btn = c | s | mn | sc;
        ns = m_state;
        case (m_state)
            M_IDLE: begin
                if (c) begin
                    m_min = 0;
                    m_sec = 0;
                end else if (s) begin
                    if (m_min != 0 || m_sec != 0) begin
                        ns = M_LOAD;
                        m_armed = 1'b0;
                    end
                end else if (mn) begin
                    m_min = (m_min + 1) % 100;
                end else if (sc) begin
                    m_sec = (m_sec + 1) % 60;
                end
            end
            M_LOAD: if (tk) ns = M_RUN;
            M_RUN: begin
                if (c)                  ns = M_IDLE;
                else if (s)             ns = M_PAUSE;
                else if (m_armed && z) begin
                    ns = M_ALARM;
                    m_cnt = ALARM_SECS;
                end
                if (!z) m_armed = 1'b1;
            end
            M_PAUSE: begin
                if (c)      ns = M_IDLE;
                else if (s) ns = M_RUN;
            end
            M_ALARM: begin
                if (any_btn) begin
                    ns = M_IDLE;
                end else if (tk) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) ns = M_IDLE;
                end
            end
            default: ns = M_IDLE;
        endcase
        m_state = ns;
    endtask

    // Called at a negedge: apply inputs for one cycle, advance the model,
    // return at the following negedge with pulses removed.
    task automatic step(input bit c, input bit s, input bit mn,
                        input bit sc, input bit tk, input bit z);
        btn_clear = c;
        btn_start = s;
        btn_min   = mn;
        btn_sec   = sc;
        tick_1Hz  = tk;
        cnt_zero  = z;
        @(posedge clk);
        #1;
        model_step(c, s, mn, sc, tk, z);
        btn_clear = 1'b0;
        btn_start = 1'b0;
        btn_min   = 1'b0;
        btn_sec   = 1'b0;
        tick_1Hz  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_vec() !== 23'd0) begin
            failures++;
            $display("FAIL reset_state: got %h required %h", dut_vec(), 23'd0);
        end
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_load_sequence();
        repeat (3) step(0, 0, 1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 1, 0, 1);
        checks++;
        if (dut_setpoint() !== 16'h0302) begin
            failures++;
            $display("FAIL setpoint_0302: got %h required 0302", dut_setpoint());
        end
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 3'd1 || load !== 1'b1 || enable !== 1'b0 || enable_timer !== 1'b1) begin
                failures++;
                $display("FAIL load_hold[%0d]: state=%0d load=%b enable=%b enable_timer=%b required 1 1 0 1",
                         i, state, load, enable, enable_timer);
            end
            if (i < 2) step(0, 0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (state !== 3'd2 || load !== 1'b0 || enable !== 1'b1 || enable_timer !== 1'b1) begin
            failures++;
            $display("FAIL run_after_tick: state=%0d load=%b enable=%b enable_timer=%b required 2 0 1 1",
                     state, load, enable, enable_timer);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL run_model: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_wraps();
        step(1, 0, 0, 0, 0, 1);   // abort RUN, setpoint kept
        checks++;
        if (state !== 3'd0 || enable_timer !== 1'b0 || dut_setpoint() !== 16'h0302) begin
            failures++;
            $display("FAIL abort_keeps_setpoint: state=%0d et=%b sp=%h required 0 0 0302",
                     state, enable_timer, dut_setpoint());
        end
        step(1, 0, 0, 0, 0, 1);
        repeat (59) step(0, 0, 0, 1, 0, 1);
        checks++;
        if (dut_setpoint() !== 16'h0059) begin
            failures++;
            $display("FAIL sec_59: got %h required 0059", dut_setpoint());
        end
        step(0, 0, 0, 1, 0, 1);
        checks++;
        if (dut_setpoint() !== 16'h0000) begin
            failures++;
            $display("FAIL sec_wrap: got %h required 0000", dut_setpoint());
        end
        repeat (99) step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        checks++;
        if (dut_setpoint() !== 16'h9901) begin
            failures++;
            $display("FAIL min_99: got %h required 9901", dut_setpoint());
        end
        step(0, 0, 1, 0, 0, 1);
        checks++;
        if (dut_setpoint() !== 16'h0001) begin
            failures++;
            $display("FAIL min_wrap: got %h required 0001", dut_setpoint());
        end
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        checks++;
        if (state !== 3'd0 || load !== 1'b0) begin
            failures++;
            $display("FAIL start_at_zero: state=%0d load=%b required 0 0", state, load);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL wraps_model: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_pause();
        step(0, 0, 1, 0, 0, 1);   // 01:00
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 3'd3 || enable !== 1'b0 || enable_timer !== 1'b1) begin
                failures++;
                $display("FAIL pause[%0d]: state=%0d enable=%b enable_timer=%b required 3 0 1",
                         i, state, enable, enable_timer);
            end
            step(0, 0, 0, 0, 1, 1);
        end
        step(0, 1, 0, 0, 0, 1);
        checks++;
        if (state !== 3'd2 || enable !== 1'b1) begin
            failures++;
            $display("FAIL resume: state=%0d enable=%b required 2 1", state, enable);
        end
        step(1, 0, 0, 0, 0, 1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL pause_model: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_armed_alarm();
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 1);
            checks++;
            if (state !== 3'd2 || alarm !== 1'b0) begin
                failures++;
                $display("FAIL not_armed[%0d]: state=%0d alarm=%b required 2 0", i, state, alarm);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL arming_cycle: state=%0d required 2", state);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (state !== 3'd4 || alarm !== 1'b1 || enable_timer !== 1'b1 || enable !== 1'b0) begin
            failures++;
            $display("FAIL alarm_entry: state=%0d alarm=%b et=%b en=%b required 4 1 1 0",
                     state, alarm, enable_timer, enable);
        end
        // Ticks 1 and 2 keep the alarm on, a quiet cycle in between.
        for (int t = 1; t <= 2; t++) begin
            step(0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 1);
            checks++;
            if (state !== 3'd4 || alarm !== 1'b1) begin
                failures++;
                $display("FAIL alarm_tick%0d: state=%0d alarm=%b required 4 1", t, state, alarm);
            end
        end
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (state !== 3'd0 || alarm !== 1'b0 || dut_setpoint() !== 16'h0100) begin
            failures++;
            $display("FAIL alarm_expire: state=%0d alarm=%b sp=%h required 0 0 0100",
                     state, alarm, dut_setpoint());
        end
        // Second run, silenced by btn_clear.
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("FAIL alarm_reentry: state=%0d required 4", state);
        end
        step(1, 0, 0, 0, 0, 1);
        checks++;
        if (dut_vec() !== exp_vec() || state !== 3'd0 || dut_setpoint() !== 16'h0100) begin
            failures++;
            $display("FAIL alarm_clear: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        step(1, 0, 1, 0, 0, 1);
        checks++;
        if (dut_setpoint() !== 16'h0000) begin
            failures++;
            $display("FAIL clear_beats_min: got %h required 0000", dut_setpoint());
        end
        step(0, 0, 1, 1, 0, 1);   // min beats sec
        checks++;
        if (dut_setpoint() !== 16'h0100) begin
            failures++;
            $display("FAIL min_beats_sec: got %h required 0100", dut_setpoint());
        end
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 1);   // tick and clear together in LOAD
        checks++;
        if (state !== 3'd2 || load !== 1'b0 || enable !== 1'b1) begin
            failures++;
            $display("FAIL load_tick_vs_clear: state=%0d load=%b enable=%b required 2 0 1",
                     state, load, enable);
        end
        step(1, 0, 0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 0, 0, 1);
        checks++;
        if (state !== 3'd1 || load !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_load: state=%0d load=%b required 1 1", state, load);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 23'd0) begin
            failures++;
            $display("FAIL async_reset: got %h required %h", dut_vec(), 23'd0);
        end
        tick_1Hz = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick_1Hz = 1'b0;
        checks++;
        if (dut_vec() !== 23'd0) begin
            failures++;
            $display("FAIL reset_held: got %h required %h", dut_vec(), 23'd0);
        end
        reset = 1'b1;
        step(0, 0, 0, 0, 1, 1);
        checks++;
        if (load !== 1'b0 || dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int fail_prints;
        fail_prints = 0;
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 12) == 0, ($urandom % 8) == 0, ($urandom % 5) == 0,
                 ($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                if (fail_prints < 10) begin
                    fail_prints++;
                    $display("FAIL random_cycle[%0d]: got %h required %h", i, dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_wraps();
        test_pause();
        test_armed_alarm();
        test_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
